// File: rtl/display_scan_capture_if.sv
// Scanned 7-segment display bus plus the decoded capture results.
// The selector (master) drives Sw/Seg; the capture block (slave) drives the rest.
interface display_scan_capture_if;
    logic       Sw0;
    logic       Sw1;
    logic       Sw2;
    logic       Sw3;
    logic [6:0] Seg;
    logic [3:0] Dig0;
    logic [3:0] Dig1;
    logic [3:0] Dig2;
    logic [3:0] Dig3;
    logic [3:0] DigValid;
    logic       FrameDone;
    logic       SegErr;
    logic       OrderErr;
    logic       Stale;

    modport master (
        output Sw0, Sw1, Sw2, Sw3, Seg,
        input  Dig0, Dig1, Dig2, Dig3, DigValid, FrameDone, SegErr, OrderErr, Stale
    );

    modport slave (
        input  Sw0, Sw1, Sw2, Sw3, Seg,
        output Dig0, Dig1, Dig2, Dig3, DigValid, FrameDone, SegErr, OrderErr, Stale
    );
endinterface

// File: rtl/display_scan_capture.sv
// Recovers hex digits from a scanned 4-digit 7-segment display bus.
// state     | meaning
// IDLE      | no single digit enable asserted
// SETTLE    | counting stable cycles of one digit select and segment pattern
// CAPTURED  | digit sampled, waiting for select or segment change
module display_scan_capture #(
    parameter int unsigned SETTLE         = 4,
    parameter int unsigned TIMEOUT        = 1024,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          SW_ACTIVE_LOW  = 1'b0
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    display_scan_capture_if.slave bus
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SETTLE   = 2'd1;
    localparam logic [1:0] ST_CAPTURED = 2'd2;

    localparam logic [7:0]  SETTLE_C  = 8'(SETTLE);
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    logic [3:0] sw_q1, sw_q2;
    logic [6:0] seg_q1, seg_q2;
    logic [3:0] sw_hi;
    logic [6:0] seg_hi;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sw_q1  <= '0;
            sw_q2  <= '0;
            seg_q1 <= '0;
            seg_q2 <= '0;
        end else begin
            sw_q1  <= {bus.Sw3, bus.Sw2, bus.Sw1, bus.Sw0};
            sw_q2  <= sw_q1;
            seg_q1 <= bus.Seg;
            seg_q2 <= seg_q1;
        end
    end

    assign sw_hi  = SW_ACTIVE_LOW  ? ~sw_q2  : sw_q2;
    assign seg_hi = SEG_ACTIVE_LOW ? ~seg_q2 : seg_q2;

    logic       sel_ok;
    logic [1:0] sel_idx;

    always_comb begin
        sel_ok  = 1'b0;
        sel_idx = 2'd0;
        case (sw_hi)
            4'b0001: begin sel_ok = 1'b1; sel_idx = 2'd0; end
            4'b0010: begin sel_ok = 1'b1; sel_idx = 2'd1; end
            4'b0100: begin sel_ok = 1'b1; sel_idx = 2'd2; end
            4'b1000: begin sel_ok = 1'b1; sel_idx = 2'd3; end
            default: ;
        endcase
    end

    logic [1:0] state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [1:0] lat_idx, lat_idx_nxt;
    logic [6:0] lat_seg, lat_seg_nxt;
    logic       recap, recap_nxt;
    logic       restart, cap_fire, same;

    assign same = (sel_idx == lat_idx) && (seg_hi == lat_seg);

    // recap marks a re-sample of the digit just captured; it survives segment-only restarts
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        lat_idx_nxt = lat_idx;
        lat_seg_nxt = lat_seg;
        recap_nxt   = recap;
        restart     = 1'b0;
        cap_fire    = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (sel_ok) begin
                    restart   = 1'b1;
                    recap_nxt = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (!sel_ok) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (same) begin
                    cnt_nxt = cnt + 8'd1;
                end else begin
                    restart = 1'b1;
                    if (sel_idx != lat_idx) recap_nxt = 1'b0;
                end
            end
            ST_CAPTURED: begin
                if (!sel_ok) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (!same) begin
                    restart   = 1'b1;
                    recap_nxt = (sel_idx == lat_idx);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
        if (restart) begin
            state_nxt   = ST_SETTLE;
            cnt_nxt     = 8'd1;
            lat_idx_nxt = sel_idx;
            lat_seg_nxt = seg_hi;
        end
        if (state_nxt == ST_SETTLE && cnt_nxt == SETTLE_C) begin
            cap_fire  = 1'b1;
            state_nxt = ST_CAPTURED;
        end
    end

    logic       cap_req;
    logic [1:0] cap_idx;
    logic [6:0] cap_seg;
    logic       cap_recap;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lat_idx   <= '0;
            lat_seg   <= '0;
            recap     <= 1'b0;
            cap_req   <= 1'b0;
            cap_idx   <= '0;
            cap_seg   <= '0;
            cap_recap <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lat_idx   <= lat_idx_nxt;
            lat_seg   <= lat_seg_nxt;
            recap     <= recap_nxt;
            cap_req   <= cap_fire;
            cap_idx   <= lat_idx_nxt;
            cap_seg   <= lat_seg_nxt;
            cap_recap <= recap_nxt;
        end
    end

    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h07:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h39:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    logic [4:0]       dec;
    logic [3:0]       cap_onehot;
    logic [3:0]       valid_set;
    logic [3:0][3:0]  dig;
    logic [3:0]       dig_valid;
    logic             frame_done, seg_err, order_err, stale;
    logic [15:0]      idle_cnt;
    logic [1:0]       last_idx;
    logic             order_free;

    assign dec        = seg_decode(cap_seg);
    assign cap_onehot = 4'b0001 << cap_idx;
    assign valid_set  = dig_valid | cap_onehot;

    // order_free exempts the first capture after reset or after the display went stale
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            dig        <= '0;
            dig_valid  <= '0;
            frame_done <= 1'b0;
            seg_err    <= 1'b0;
            order_err  <= 1'b0;
            stale      <= 1'b0;
            idle_cnt   <= '0;
            last_idx   <= '0;
            order_free <= 1'b1;
        end else begin
            frame_done <= 1'b0;
            seg_err    <= 1'b0;
            order_err  <= 1'b0;
            if (cap_req) begin
                idle_cnt   <= '0;
                stale      <= 1'b0;
                order_err  <= !order_free && !cap_recap && (cap_idx != last_idx + 2'd1);
                last_idx   <= cap_idx;
                order_free <= 1'b0;
                if (dec[4]) begin
                    dig[cap_idx] <= dec[3:0];
                    dig_valid    <= valid_set;
                    frame_done   <= (cap_idx == 2'd3) && (&valid_set);
                end else begin
                    seg_err   <= 1'b1;
                    dig_valid <= dig_valid & ~cap_onehot;
                end
            end else if (idle_cnt != 16'hFFFF) begin
                idle_cnt <= idle_cnt + 16'd1;
                if (idle_cnt + 16'd1 == TIMEOUT_C) begin
                    stale      <= 1'b1;
                    dig_valid  <= '0;
                    order_free <= 1'b1;
                end
            end
        end
    end

    assign bus.Dig0      = dig[0];
    assign bus.Dig1      = dig[1];
    assign bus.Dig2      = dig[2];
    assign bus.Dig3      = dig[3];
    assign bus.DigValid  = dig_valid;
    assign bus.FrameDone = frame_done;
    assign bus.SegErr    = seg_err;
    assign bus.OrderErr  = order_err;
    assign bus.Stale     = stale;

endmodule

// File: tb/tb_display_scan_capture.sv
// Bench for display_scan_capture: directed scans plus random slots against a slot-level model.
module tb_display_scan_capture;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    display_scan_capture_if bus();

    display_scan_capture #(
        .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .SEG_ACTIVE_LOW(1'b1), .SW_ACTIVE_LOW(1'b0)
    ) dut (
        .Clock(clk),
        .Reset_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int         due;
        int         idx;
        logic [6:0] seg;
        bit         recap;
    } cap_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // expected display state
    logic [3:0] m_dig [4];
    logic [3:0] m_valid;
    logic       m_stale, m_fd, m_se, m_oe;
    int         m_since, m_last;
    bit         m_free;
    int         exp_frames, got_frames;
    cap_t       pend[$];

    // slot history, used to predict when a capture lands
    bit         p_valid;
    int         p_idx;
    logic [6:0] p_seg;
    int         stable_len;
    bit         run_cap;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_dig[k] = 4'h0;
        m_valid = 4'h0; m_stale = 1'b0; m_fd = 1'b0; m_se = 1'b0; m_oe = 1'b0;
        m_since = 0; m_last = 0; m_free = 1'b1;
        pend.delete();
        p_valid = 1'b0; p_idx = 0; p_seg = 7'h00; stable_len = 0; run_cap = 1'b0;
        cyc = 0;
    endtask

    task automatic model_step();
        cap_t c;
        int   v;
        m_fd = 1'b0; m_se = 1'b0; m_oe = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            c = pend.pop_front();
            v = -1;
            for (int k = 0; k < 16; k++) if (seg_tab[k] == c.seg) v = k;
            if (!m_free && !c.recap && c.idx != (m_last + 1) % 4) m_oe = 1'b1;
            m_last = c.idx;
            m_free = 1'b0;
            if (v >= 0) begin
                m_dig[c.idx]   = 4'(v);
                m_valid[c.idx] = 1'b1;
                if (c.idx == 3 && m_valid == 4'hF) begin
                    m_fd = 1'b1;
                    exp_frames++;
                end
            end else begin
                m_se = 1'b1;
                m_valid[c.idx] = 1'b0;
            end
            m_since = 0;
            m_stale = 1'b0;
        end else if (m_since < 65535) begin
            m_since++;
            if (m_since == TIMEOUT) begin
                m_stale = 1'b1;
                m_valid = 4'h0;
                m_free  = 1'b1;
            end
        end
    endtask

    task automatic compare();
        chk("digits", {bus.Dig3, bus.Dig2, bus.Dig1, bus.Dig0},
            {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
        chk("dig_valid", bus.DigValid, m_valid);
        chk("pulses_fd_se_oe", {bus.FrameDone, bus.SegErr, bus.OrderErr}, {m_fd, m_se, m_oe});
        chk("stale", bus.Stale, m_stale);
        if (bus.FrameDone) got_frames++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_step();
        compare();
    endtask

    // hold one select/segment pattern (segment given active-high) for len cycles
    task automatic run_slot(input logic [3:0] sw, input logic [6:0] seg, input int len);
        bit   v;
        int   ix;
        cap_t c;
        v  = ($countones(sw) == 1);
        ix = 0;
        for (int k = 0; k < 4; k++) if (sw[k]) ix = k;
        if (!(v && p_valid && ix == p_idx)) run_cap = 1'b0;
        if (!(v && p_valid && ix == p_idx && seg == p_seg)) stable_len = 0;
        p_valid = v; p_idx = ix; p_seg = seg;
        {bus.Sw3, bus.Sw2, bus.Sw1, bus.Sw0} = sw;
        bus.Seg = ~seg;
        for (int i = 0; i < len; i++) begin
            stable_len++;
            if (v && stable_len == SETTLE) begin
                c.due = cyc + 4; c.idx = ix; c.seg = seg; c.recap = run_cap;
                pend.push_back(c);
                run_cap = 1'b1;
            end
            tick();
        end
    endtask

    task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        run_slot(4'b0001, s0, 8);
        run_slot(4'b0010, s1, 8);
        run_slot(4'b0100, s2, 8);
        run_slot(4'b1000, s3, 8);
    endtask

    initial begin
        logic [3:0] sw;
        logic [6:0] seg;
        int         r;
        exp_frames = 0;
        got_frames = 0;
        {bus.Sw3, bus.Sw2, bus.Sw1, bus.Sw0} = 4'b0000;
        bus.Seg = 7'h7F;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare();
        rst_n = 1'b1;

        // clean scans 1,2,3,4
        frame(7'h06, 7'h5B, 7'h4F, 7'h66);
        frame(7'h06, 7'h5B, 7'h4F, 7'h66);

        // glitch inside a slot, then a slot too short to capture
        run_slot(4'b0001, 7'h5B, 2);
        run_slot(4'b0001, 7'h4F, 6);
        run_slot(4'b0010, 7'h06, 3);
        run_slot(4'b0010, 7'h7D, 8);
        run_slot(4'b0100, 7'h3F, 8);
        run_slot(4'b1000, 7'h6F, 8);

        // undecodable pattern on digit 2
        frame(7'h06, 7'h5B, 7'h00, 7'h66);

        // out-of-order scan 0,1,3,2
        run_slot(4'b0001, 7'h3F, 8);
        run_slot(4'b0010, 7'h06, 8);
        run_slot(4'b1000, 7'h5B, 8);
        run_slot(4'b0100, 7'h4F, 8);

        // scanning stops, display goes stale, then resumes out of order
        run_slot(4'b0000, 7'h00, 80);
        run_slot(4'b0100, 7'h77, 8);
        run_slot(4'b1000, 7'h7C, 8);

        // random slots
        for (int n = 0; n < 220; n++) begin
            r = $urandom_range(0, 99);
            if (r < 25 && p_valid) sw = 4'b0001 << p_idx;
            else if (r < 75)       sw = 4'b0001 << $urandom_range(0, 3);
            else if (r < 88)       sw = 4'b0000;
            else                   sw = (4'b0011 << $urandom_range(0, 2)) | 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 80) seg = seg_tab[$urandom_range(0, 15)];
            else                            seg = 7'($urandom_range(0, 127));
            run_slot(sw, seg, $urandom_range(1, 10));
        end
        frame(7'h39, 7'h5E, 7'h79, 7'h71);

        // reset mid-settle with two enables asserted
        run_slot(4'b0001, 7'h06, 2);
        bus.Sw1 = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        run_slot(4'b0011, 7'h06, 12);
        frame(7'h7F, 7'h07, 7'h6D, 7'h3F);
        run_slot(4'b0000, 7'h00, SETTLE + 6);

        chk("frame_count", got_frames, exp_frames);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
